// File: rtl/sha3_host_ctrl.sv
// sha3_host_ctrl
// Host-side master for a SHA3 core stream interface. A start command with a
// non-zero length streams that many 64-bit words from a ready/valid source
// straight into the core, flagging the final word with in_done. The controller
// then gathers DIGEST_WORDS output words into a parallel digest register and
// holds it until the consumer acknowledges.
//
// Ports
//   clk, rst_n                 clock (rising edge), async active-low reset
//   start, msg_len             command pulse and message length in words
//   src_valid/src_ready/src_data   message source (ready/valid)
//   in_valid/in_ready/in_data/in_done  message stream to the core
//   out_valid/out_ready/out_data   digest stream from the core
//   busy                       core reports a hash in progress
//   digest, digest_valid       assembled digest (first word in [63:0])
//   digest_ack                 consumer ack; leaves HOLD or ERR
//   timeout_err                core stalled too long between digest words
//   idle                       controller is waiting for a command
module sha3_host_ctrl #(
    parameter int DIGEST_WORDS = 4,
    parameter int LEN_W        = 16,
    parameter int TIMEOUT_CYC  = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [LEN_W-1:0]          msg_len,
    input  logic                      src_valid,
    output logic                      src_ready,
    input  logic [63:0]               src_data,
    output logic                      in_valid,
    input  logic                      in_ready,
    output logic [63:0]               in_data,
    output logic                      in_done,
    input  logic                      out_valid,
    output logic                      out_ready,
    input  logic [63:0]               out_data,
    input  logic                      busy,
    output logic [64*DIGEST_WORDS-1:0] digest,
    output logic                      digest_valid,
    input  logic                      digest_ack,
    output logic                      timeout_err,
    output logic                      idle
);

    localparam int WIDX_W = (DIGEST_WORDS > 1) ? $clog2(DIGEST_WORDS) : 1;
    localparam int TMR_W  = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam logic [WIDX_W-1:0] WIDX_LAST = WIDX_W'(DIGEST_WORDS - 1);
    localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FEED,
        S_COLLECT,
        S_HOLD,
        S_ERR
    } state_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [WIDX_W-1:0]  widx_q, widx_d;
    logic [TMR_W-1:0]   timer_q, timer_d;
    logic               dig_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            remaining_q <= '0;
            widx_q      <= '0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            widx_q      <= widx_d;
            timer_q     <= timer_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        widx_d      = widx_q;
        timer_d     = timer_q;
        dig_we      = 1'b0;
        in_valid    = 1'b0;
        in_done     = 1'b0;
        src_ready   = 1'b0;
        out_ready   = 1'b0;
        in_data     = src_data;

        case (state_q)
            S_IDLE: begin
                if (start && (msg_len != '0) && !busy) begin
                    state_d     = S_FEED;
                    remaining_d = msg_len;
                end
            end
            S_FEED: begin
                // Zero-latency pass-through: source and core handshake directly.
                in_valid  = src_valid;
                src_ready = in_ready;
                in_done   = src_valid && (remaining_q == LEN_W'(1));
                if (src_valid && in_ready) begin
                    remaining_d = remaining_q - LEN_W'(1);
                    if (remaining_q == LEN_W'(1)) begin
                        state_d = S_COLLECT;
                        widx_d  = '0;
                        timer_d = '0;
                    end
                end
            end
            S_COLLECT: begin
                out_ready = 1'b1;
                if (out_valid) begin
                    // A word arriving on the expiry cycle still counts.
                    dig_we  = 1'b1;
                    timer_d = '0;
                    if (widx_q == WIDX_LAST) begin
                        state_d = S_HOLD;
                    end else begin
                        widx_d = widx_q + WIDX_W'(1);
                    end
                end else if ((TIMEOUT_CYC != 0) && (timer_q == TMR_LAST)) begin
                    state_d = S_ERR;
                end else if (timer_q != '1) begin
                    timer_d = timer_q + TMR_W'(1);
                end
            end
            S_HOLD, S_ERR: begin
                if (digest_ack) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // One register per digest word, loaded when its index is being collected.
    genvar gi;
    generate
        for (gi = 0; gi < DIGEST_WORDS; gi++) begin : g_word
            logic [63:0] word_q;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    word_q <= '0;
                end else if (dig_we && (widx_q == WIDX_W'(gi))) begin
                    word_q <= out_data;
                end
            end
            assign digest[64*gi +: 64] = word_q;
        end
    endgenerate

    assign digest_valid = (state_q == S_HOLD);
    assign timeout_err  = (state_q == S_ERR);
    assign idle         = (state_q == S_IDLE);

endmodule

// File: tb/tb_sha3_host_ctrl.sv
// Directed self-checking bench for sha3_host_ctrl (TIMEOUT_CYC=16).
module tb_sha3_host_ctrl;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [15:0]  msg_len;
    logic         src_valid;
    logic         src_ready;
    logic [63:0]  src_data;
    logic         in_valid;
    logic         in_ready;
    logic [63:0]  in_data;
    logic         in_done;
    logic         out_valid;
    logic         out_ready;
    logic [63:0]  out_data;
    logic         busy;
    logic [255:0] digest;
    logic         digest_valid;
    logic         digest_ack;
    logic         timeout_err;
    logic         idle;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sha3_host_ctrl #(
        .DIGEST_WORDS(4),
        .LEN_W(16),
        .TIMEOUT_CYC(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .msg_len(msg_len),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_done(in_done),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .digest(digest), .digest_valid(digest_valid),
        .digest_ack(digest_ack), .timeout_err(timeout_err), .idle(idle)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] len);
        start   = 1'b1;
        msg_len = len;
        tick();
        start   = 1'b0;
        #1;
        chk("start_leaves_idle", idle, 1'b0);
    endtask

    task automatic feed_word(input logic [63:0] d, input logic last);
        src_valid = 1'b1;
        src_data  = d;
        in_ready  = 1'b1;
        #1;
        chk("feed_in_valid", in_valid, 1'b1);
        chk("feed_in_data", in_data, d);
        chk("feed_in_done", in_done, last);
        chk("feed_src_ready", src_ready, 1'b1);
        tick();
        src_valid = 1'b0;
        in_ready  = 1'b0;
    endtask

    task automatic collect(input logic [255:0] words);
        for (int i = 0; i < 4; i++) begin
            out_valid = 1'b1;
            out_data  = words[64*i +: 64];
            #1;
            chk("collect_out_ready", out_ready, 1'b1);
            tick();
        end
        out_valid = 1'b0;
        #1;
        chk("hold_digest_valid", digest_valid, 1'b1);
        chk("hold_digest", digest, words);
        chk("hold_out_ready", out_ready, 1'b0);
    endtask

    task automatic ack();
        digest_ack = 1'b1;
        tick();
        digest_ack = 1'b0;
        #1;
        chk("ack_idle", idle, 1'b1);
        chk("ack_digest_valid", digest_valid, 1'b0);
        chk("ack_timeout_err", timeout_err, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] w1, w2, w3, w4, w6;
        bit sv_pat [16]  = '{1,0,1,1,0,1,1,1,0,1,1,1,1,1,1,1};
        bit rdy_pat [16] = '{0,1,1,0,1,1,0,1,1,1,0,1,1,1,1,1};
        logic [63:0] got_q [5];
        int k, dones, cyc;

        w1 = {64'h1111_0000_0000_0003, 64'h1111_0000_0000_0002,
              64'h1111_0000_0000_0001, 64'h1111_0000_0000_0000};
        w2 = {64'h2222_DDDD_0000_0003, 64'h2222_CCCC_0000_0002,
              64'h2222_BBBB_0000_0001, 64'h2222_AAAA_0000_0000};
        w3 = {64'h3333_0000_0000_00FF, 64'h3333_0000_0000_00EE,
              64'h3333_0000_0000_00DD, 64'h3333_0000_0000_00CC};
        w4 = {64'h4444_0000_0000_0004, 64'h4444_0000_0000_0003,
              64'h4444_0000_0000_0002, 64'h4444_0000_0000_0001};
        w6 = {64'h6666_0000_0000_0004, 64'h6666_0000_0000_0003,
              64'h6666_0000_0000_0002, 64'h6666_0000_0000_0001};

        rst_n = 1'b0; start = 1'b0; msg_len = '0; src_valid = 1'b0; src_data = '0;
        in_ready = 1'b0; out_valid = 1'b0; out_data = '0; busy = 1'b0; digest_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_idle", idle, 1'b1);
        chk("rst_digest", digest, 256'h0);
        chk("rst_digest_valid", digest_valid, 1'b0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        chk("rst_in_valid", in_valid, 1'b0);
        chk("rst_src_ready", src_ready, 1'b0);
        chk("rst_out_ready", out_ready, 1'b0);
        rst_n = 1'b1;
        tick();

        // 1: three words back to back, then four digest words.
        do_start(16'd3);
        feed_word(64'hAAAA, 1'b0);
        feed_word(64'hBBBB, 1'b0);
        feed_word(64'hCCCC, 1'b1);
        #1;
        chk("t1_no_more_in_valid", in_valid, 1'b0);
        collect(w1);
        ack();
        $display("msg 1 (len 3 streaming) complete");

        // 2: gapped source and stalling core.
        do_start(16'd5);
        k = 0; dones = 0; cyc = 0;
        while (k < 5 && cyc < 40) begin
            src_valid = sv_pat[cyc % 16];
            src_data  = 64'hA500 + 64'(k);
            in_ready  = rdy_pat[cyc % 16];
            #1;
            chk("t2_src_ready_eq_in_ready", src_ready, in_ready);
            chk("t2_in_valid_eq_src_valid", in_valid, src_valid);
            if (in_valid && in_ready) begin
                got_q[k] = in_data;
                chk("t2_in_done", in_done, (k == 4));
                if (in_done) dones++;
                k++;
            end
            tick();
            cyc++;
        end
        src_valid = 1'b0;
        in_ready  = 1'b0;
        chk("t2_beats_within_budget", k, 5);
        chk("t2_in_done_count", dones, 1);
        for (int i = 0; i < 5; i++) chk("t2_order", got_q[i], 64'hA500 + 64'(i));
        #1;
        chk("t2_in_collect", out_ready, 1'b1);
        collect(w2);
        ack();
        $display("msg 2 (len 5 gapped) complete");

        // 3a: no digest words -> timeout 16 cycles after COLLECT entry.
        do_start(16'd1);
        feed_word(64'h3A, 1'b1);
        repeat (15) tick();
        chk("t3_no_err_at_15", timeout_err, 1'b0);
        chk("t3_collect_at_15", out_ready, 1'b1);
        tick();
        chk("t3_err_at_16", timeout_err, 1'b1);
        chk("t3_err_out_ready", out_ready, 1'b0);
        chk("t3_err_not_idle", idle, 1'b0);
        ack();
        $display("msg 3a (timeout) complete");

        // 3b: first word lands on the expiry cycle -> no error.
        do_start(16'd1);
        feed_word(64'h3B, 1'b1);
        repeat (15) tick();
        collect(w3);
        chk("t3b_no_err", timeout_err, 1'b0);
        ack();
        $display("msg 3b (late word) complete");

        // 4: ignored starts.
        busy = 1'b1;
        start = 1'b1; msg_len = 16'd2;
        tick();
        start = 1'b0; busy = 1'b0;
        src_valid = 1'b1; in_ready = 1'b1;
        #1;
        chk("t4_busy_start_idle", idle, 1'b1);
        chk("t4_busy_no_in_valid", in_valid, 1'b0);
        chk("t4_busy_no_src_ready", src_ready, 1'b0);
        start = 1'b1; msg_len = 16'd0;
        tick();
        start = 1'b0;
        #1;
        chk("t4_zero_len_idle", idle, 1'b1);
        chk("t4_zero_len_no_in_valid", in_valid, 1'b0);
        src_valid = 1'b0; in_ready = 1'b0;
        do_start(16'd2);
        start = 1'b1; msg_len = 16'd7;
        feed_word(64'h4001, 1'b0);
        start = 1'b0;
        feed_word(64'h4002, 1'b1);
        src_valid = 1'b1; in_ready = 1'b1;
        #1;
        chk("t4_feed_start_ignored", in_valid, 1'b0);
        chk("t4_in_collect", out_ready, 1'b1);
        src_valid = 1'b0; in_ready = 1'b0;

        // 5: surplus core word is not consumed while holding.
        collect(w4);
        out_valid = 1'b1;
        out_data  = 64'hDEAD_BEEF_0000_0005;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("t5_out_ready_low", out_ready, 1'b0);
            chk("t5_digest_stable", digest, w4);
            tick();
        end
        out_valid = 1'b0;
        chk("t5_still_valid", digest_valid, 1'b1);
        ack();
        chk("t5_digest_kept_after_ack", digest, w4);
        $display("msg 4/5 (ignored starts, hold) complete");

        // 6: reset in the middle of FEED.
        do_start(16'd4);
        feed_word(64'h6001, 1'b0);
        feed_word(64'h6002, 1'b0);
        src_valid = 1'b1; src_data = 64'h6003; in_ready = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_in_valid", in_valid, 1'b0);
        chk("t6_rst_src_ready", src_ready, 1'b0);
        chk("t6_rst_idle", idle, 1'b1);
        chk("t6_rst_digest", digest, 256'h0);
        tick();
        rst_n = 1'b1;
        src_valid = 1'b0; in_ready = 1'b0;
        tick();
        do_start(16'd2);
        feed_word(64'h6101, 1'b0);
        feed_word(64'h6102, 1'b1);
        collect(w6);
        ack();
        $display("msg 6 (reset mid-feed, restart) complete");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
